pulse_generator_mc: RTL

- Multi-channel successor to the single-channel periodic pulse generator.
- Each of CHANNELS independent channels runs an N-bit period counter in one of three modes: periodic single-cycle pulse, PWM (programmable high width), or finite burst with a done flag.
- A shared sync input realigns all channels.
- Sits in the timing/peripheral layer: drives UART baud ticks, LED PWM and sampling strobes.

---
 rtl/pulse_gen_pkg.sv | 12 +
 rtl/adder_n.sv | 13 +
 rtl/comparator_eq.sv | 13 +
 rtl/comparator_lt.sv | 13 +
 rtl/pulse_channel.sv | 107 ++++++++++
 rtl/pulse_generator_mc.sv | 36 +++
 6 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared mode encoding for the multi-channel pulse generator.
// Channel and top both import this package.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    PULSE = 2'b00,
    PWM   = 2'b01,
    BURST = 2'b10,
    OFF   = 2'b11
  } pulse_mode_t;

endpackage

// File: rtl/adder_n.sv
// N-bit modulo-2^N adder used for every counter increment.
// Latency: combinational; backpressure: none.
module adder_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/comparator_eq.sv
// N-bit equality comparator.
// Latency: combinational; backpressure: none.
module comparator_eq #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         eq
);

  assign eq = (a == b);

endmodule

// File: rtl/comparator_lt.sv
// Unsigned N-bit less-than comparator.
// Latency: combinational; backpressure: none.
module comparator_lt #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt
);

  assign lt = (a < b);

endmodule

// File: rtl/pulse_channel.sv
// One channel: period counter, burst counter, registered out and sticky done.
// Latency: out/done registered, 1 edge after inputs; backpressure: none.
module pulse_channel
  import pulse_gen_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         sync,
  input  pulse_mode_t  mode,
  input  logic [N-1:0] ticks,
  input  logic [N-1:0] width,
  input  logic [N-1:0] burst,
  output logic         out,
  output logic         done
);

  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] ALL1 = '1;
  localparam logic [N-1:0] ZERO = '0;

  logic [N-1:0] cnt, cnt_n, bcnt, bcnt_n;
  logic [N-1:0] cnt_inc, bcnt_inc, ticks_m1, cnt_step;
  logic         out_n, done_n;
  logic         ticks_zero, burst_zero, below_term, bcnt_short, pwm_hi, terminal;

  adder_n #(.N(N)) u_cnt_inc  (.a(cnt),   .b(ONE),  .sum(cnt_inc));
  adder_n #(.N(N)) u_bcnt_inc (.a(bcnt),  .b(ONE),  .sum(bcnt_inc));
  adder_n #(.N(N)) u_ticks_m1 (.a(ticks), .b(ALL1), .sum(ticks_m1));

  comparator_eq #(.N(N)) u_ticks_zero (.a(ticks), .b(ZERO), .eq(ticks_zero));
  comparator_eq #(.N(N)) u_burst_zero (.a(burst), .b(ZERO), .eq(burst_zero));
  // Terminal is cnt >= ticks-1 so a shrunk period wraps immediately.
  comparator_lt #(.N(N)) u_term  (.a(cnt),      .b(ticks_m1), .lt(below_term));
  comparator_lt #(.N(N)) u_bdone (.a(bcnt_inc), .b(burst),    .lt(bcnt_short));
  comparator_lt #(.N(N)) u_pwm   (.a(cnt_step), .b(width),    .lt(pwm_hi));

  assign terminal = ~below_term;
  assign cnt_step = terminal ? ZERO : cnt_inc;

  always_comb begin
    cnt_n  = cnt;
    bcnt_n = bcnt;
    done_n = done;
    out_n  = 1'b0;
    unique case (mode)
      OFF: ;
      BURST: begin
        if (!ena) begin
          cnt_n  = ZERO;
          bcnt_n = ZERO;
          done_n = 1'b0;
        end else if (!done && !ticks_zero) begin
          if (burst_zero) begin
            done_n = 1'b1;
          end else begin
            cnt_n = cnt_step;
            out_n = terminal;
            if (terminal) begin
              bcnt_n = bcnt_inc;
              done_n = ~bcnt_short;
            end
          end
        end
      end
      PWM: begin
        bcnt_n = ZERO;
        done_n = 1'b0;
        if (ena && !ticks_zero) begin
          cnt_n = cnt_step;
          out_n = pwm_hi;
        end
      end
      default: begin
        bcnt_n = ZERO;
        done_n = 1'b0;
        if (ena && !ticks_zero) begin
          cnt_n = cnt_step;
          out_n = terminal;
        end
      end
    endcase
    if (sync) begin
      cnt_n  = ZERO;
      bcnt_n = ZERO;
      done_n = 1'b0;
      out_n  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      bcnt <= '0;
      out  <= 1'b0;
      done <= 1'b0;
    end else begin
      cnt  <= cnt_n;
      bcnt <= bcnt_n;
      out  <= out_n;
      done <= done_n;
    end
  end

endmodule

// File: rtl/pulse_generator_mc.sv
// Multi-channel pulse/PWM/burst generator with a shared realigning sync.
// Latency: outputs registered, 1 edge after inputs; backpressure: none.
module pulse_generator_mc
  import pulse_gen_pkg::*;
#(
  parameter int N        = 8,
  parameter int CHANNELS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS-1:0]          ena,
  input  logic                         sync,
  input  pulse_mode_t [CHANNELS-1:0]   mode,
  input  logic [CHANNELS-1:0][N-1:0]   ticks,
  input  logic [CHANNELS-1:0][N-1:0]   width,
  input  logic [CHANNELS-1:0][N-1:0]   burst,
  output logic [CHANNELS-1:0]          out,
  output logic [CHANNELS-1:0]          done
);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    pulse_channel #(.N(N)) u_ch (
      .clk   (clk),
      .rst   (rst),
      .ena   (ena[ch]),
      .sync  (sync),
      .mode  (mode[ch]),
      .ticks (ticks[ch]),
      .width (width[ch]),
      .burst (burst[ch]),
      .out   (out[ch]),
      .done  (done[ch])
    );
  end

endmodule
